// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point sequential multiplier.
//   fxp_state_e   : controller states (IDLE, CALC, NORM, DONE)
//   ROUND_TRUNC   : drop the fraction bits below the result LSB
//   ROUND_HALF_UP : add the first dropped bit back into the magnitude
package fxp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fxp_state_e;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

endpackage : fxp_pkg

// File: rtl/fxp_round_sat.sv
// Normalisation stage: rescales the raw 2M-bit magnitude product back to the
// word format, optionally rounds, saturates and fixes the sign of zero.
//   prod    : raw magnitude product (2M bits, 2*FRAC_BITS fraction bits)
//   sign_in : sign(a) XOR sign(b)
//   mag     : result magnitude (M bits)
//   sign    : result sign, never set for a zero magnitude
//   ovf     : magnitude was saturated
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int INT_BITS   = 4,
    parameter int FRAC_BITS  = 11,
    parameter int ROUND_MODE = ROUND_HALF_UP,
    localparam int M         = INT_BITS + FRAC_BITS,
    localparam int RW        = 2 * M - FRAC_BITS + 1
) (
    input  logic [2*M-1:0] prod,
    input  logic           sign_in,
    output logic [M-1:0]   mag,
    output logic           sign,
    output logic           ovf
);

    logic [RW-1:0] shifted_s;
    logic [RW-1:0] rounded_s;
    logic          round_bit_s;

    // Rescale, round, saturate and suppress negative zero.
    always_comb begin
        shifted_s = RW'(prod >> FRAC_BITS);
        if (ROUND_MODE == ROUND_HALF_UP) begin
            round_bit_s = prod[FRAC_BITS-1];
        end else begin
            round_bit_s = 1'b0;
        end
        // One spare MSB so the rounding carry cannot wrap.
        rounded_s = shifted_s + RW'(round_bit_s);
        if (|rounded_s[RW-1:M]) begin
            mag = {M{1'b1}};
            ovf = 1'b1;
        end else begin
            mag = rounded_s[M-1:0];
            ovf = 1'b0;
        end
        if (mag != {M{1'b0}}) begin
            sign = sign_in;
        end else begin
            sign = 1'b0;
        end
    end

endmodule : fxp_round_sat

// File: rtl/fxp_seq_multiplier.sv
// Sign-magnitude fixed-point multiplier, one multiplier bit per clock.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   clear             : synchronous abort back to IDLE
//   in_valid/in_ready : operand handshake (a = multiplicand, b = multiplier)
//   out_valid/out_ready : result handshake (p = product, ovf = saturated)
// Latency is M+1 edges from operand handshake to out_valid.
module fxp_seq_multiplier
    import fxp_pkg::*;
#(
    parameter int INT_BITS   = 4,
    parameter int FRAC_BITS  = 11,
    parameter int ROUND_MODE = ROUND_HALF_UP,
    localparam int M         = INT_BITS + FRAC_BITS,
    localparam int W         = M + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p,
    output logic         ovf
);

    localparam int CW = $clog2(M + 1);

    fxp_state_e     state_q, state_d;
    logic [M-1:0]   mcand_q, mcand_d;
    logic [M-1:0]   mplier_q, mplier_d;
    logic [2*M-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sign_q, sign_d;
    logic [W-1:0]   p_q, p_d;
    logic           ovf_q, ovf_d;

    logic [M:0]     sum_s;
    logic [M-1:0]   rs_mag_s;
    logic           rs_sign_s;
    logic           rs_ovf_s;

    fxp_round_sat #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS),
        .ROUND_MODE(ROUND_MODE)
    ) u_round_sat (
        .prod   (acc_q),
        .sign_in(sign_q),
        .mag    (rs_mag_s),
        .sign   (rs_sign_s),
        .ovf    (rs_ovf_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over every other transition.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_q == CW'(M - 1)) begin
                        state_d = NORM;
                    end else begin
                        state_d = CALC;
                    end
                end
                NORM: state_d = DONE;
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values. The accumulator shifts right each step: the upper
    // half absorbs the partial product while finished low bits move down.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        p_d      = p_q;
        ovf_d    = ovf_q;
        if (mplier_q[0]) begin
            sum_s = {1'b0, acc_q[2*M-1:M]} + {1'b0, mcand_q};
        end else begin
            sum_s = {1'b0, acc_q[2*M-1:M]};
        end
        if (clear) begin
            // Abort: p keeps its last value, ovf drops.
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_d  = a[M-1:0];
                        mplier_d = b[M-1:0];
                        sign_d   = a[W-1] ^ b[W-1];
                        acc_d    = {(2*M){1'b0}};
                        cnt_d    = {CW{1'b0}};
                    end else begin
                        cnt_d    = cnt_q;
                    end
                end
                CALC: begin
                    acc_d    = {sum_s, acc_q[M-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
                NORM: begin
                    p_d   = {rs_sign_s, rs_mag_s};
                    ovf_d = rs_ovf_s;
                end
                DONE: begin
                    p_d = p_q;
                end
                default: begin
                    p_d = p_q;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= {M{1'b0}};
            mplier_q <= {M{1'b0}};
            acc_q    <= {(2*M){1'b0}};
            cnt_q    <= {CW{1'b0}};
            sign_q   <= 1'b0;
            p_q      <= {W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            p_q      <= p_d;
            ovf_q    <= ovf_d;
        end
    end

    assign p   = p_q;
    assign ovf = ovf_q;

endmodule : fxp_seq_multiplier

// File: tb/tb_fxp_seq_multiplier.sv
module tb_fxp_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_ready,  in_ready_t;
    logic        out_valid, out_valid_t;
    logic [15:0] p, p_t;
    logic        ovf, ovf_t;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fxp_seq_multiplier #(.INT_BITS(4), .FRAC_BITS(11), .ROUND_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .ovf(ovf)
    );

    fxp_seq_multiplier #(.INT_BITS(4), .FRAC_BITS(11), .ROUND_MODE(0)) dut_t (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_t), .a(a), .b(b), .out_valid(out_valid_t),
        .out_ready(out_ready), .p(p_t), .ovf(ovf_t)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p_r;
        logic        ovf_r;
        logic [15:0] p_t;
        logic        ovf_t;
        string       name;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands at a falling edge; returns after the handshake edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic watch_none(input int n, input string name);
        int seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (out_valid || out_valid_t) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        vecs[0]  = '{16'h0C00, 16'h1000, 16'h1800, 1'b0, 16'h1800, 1'b0, "1.5x2"};
        vecs[1]  = '{16'h1E00, 16'h2400, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, "pos_sat"};
        vecs[2]  = '{16'h9E00, 16'h2400, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "neg_sat"};
        vecs[3]  = '{16'h8C00, 16'h1000, 16'h9800, 1'b0, 16'h9800, 1'b0, "neg1.5x2"};
        vecs[4]  = '{16'h8000, 16'h0C00, 16'h0000, 1'b0, 16'h0000, 1'b0, "negzero"};
        vecs[5]  = '{16'h0001, 16'h0400, 16'h0001, 1'b0, 16'h0000, 1'b0, "lsb_round"};
        vecs[6]  = '{16'h0001, 16'h8400, 16'h8001, 1'b0, 16'h0000, 1'b0, "neg_lsb_round"};
        vecs[7]  = '{16'h0003, 16'h0400, 16'h0002, 1'b0, 16'h0001, 1'b0, "half_up"};
        vecs[8]  = '{16'h7FFF, 16'h0800, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0, "max_x1"};
        vecs[9]  = '{16'h0C00, 16'h5555, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, "round_ovf"};
        vecs[10] = '{16'h8C00, 16'hD555, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, "negneg_round_ovf"};
        vecs[11] = '{16'h0C00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "b_zero"};
        vecs[12] = '{16'h8800, 16'h8800, 16'h0800, 1'b0, 16'h0800, 1'b0, "neg1xneg1"};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 16'h0000;
        b         = 16'h0000;
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_p",         p,         0);
        check("rst_ovf",       ovf,       0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven products through both rounding modes.
        for (int i = 0; i < NV; i++) begin
            check({vecs[i].name, "_in_ready"}, in_ready, 1);
            start_op(vecs[i].a, vecs[i].b);
            wait_result(lat);
            check({vecs[i].name, "_latency"}, lat, 16);
            check({vecs[i].name, "_valid_t"}, out_valid_t, 1);
            check({vecs[i].name, "_p"},       p,     vecs[i].p_r);
            check({vecs[i].name, "_ovf"},     ovf,   vecs[i].ovf_r);
            check({vecs[i].name, "_p_trunc"}, p_t,   vecs[i].p_t);
            check({vecs[i].name, "_ovf_trunc"}, ovf_t, vecs[i].ovf_t);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_valid_drop"}, out_valid, 0);
        end

        // Back-pressure in DONE: result held, new operands ignored.
        out_ready = 1'b0;
        start_op(16'h1E00, 16'h2400);
        wait_result(lat);
        check("hold_latency", lat, 16);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a        = 16'h0800;
            b        = 16'h0800;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("hold_p",         p,         16'h7FFF);
            check("hold_ovf",       ovf,       1);
            check("hold_valid",     out_valid, 1);
            check("hold_in_ready",  in_ready,  0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid",    out_valid, 0);
        check("release_in_ready", in_ready,  1);
        watch_none(20, "hold_no_queued_op");

        // clear beats a handshake in the same cycle.
        @(negedge clk);
        a        = 16'h0C00;
        b        = 16'h1000;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        watch_none(20, "clear_prio_no_result");

        // clear on the 5th CALC cycle.
        start_op(16'h0C00, 16'h1000);
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_in_ready", in_ready,  1);
        check("clear_valid",    out_valid, 0);
        check("clear_p_kept",   p,         16'h7FFF);
        check("clear_ovf",      ovf,       0);
        watch_none(20, "clear_no_result");
        start_op(16'h0C00, 16'h1000);
        wait_result(lat);
        check("after_clear_latency", lat, 16);
        check("after_clear_p",       p,   16'h1800);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-CALC.
        start_op(16'h1E00, 16'h2400);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", in_ready,  1);
        check("rst_mid_valid",    out_valid, 0);
        check("rst_mid_p",        p,         0);
        check("rst_mid_ovf",      ovf,       0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_none(20, "rst_no_result");
        start_op(16'h0C00, 16'h1000);
        wait_result(lat);
        check("after_rst_latency", lat, 16);
        check("after_rst_p",       p,   16'h1800);
        check("after_rst_ovf",     ovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fxp_seq_multiplier
